alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 178 +++++++++++++++++
 tb/tb_alu_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin front end that lets two requesters share one
// combinational ALU, one operation at a time (IDLE -> EXEC -> RESP).
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   req_valid/req_ready      per-requester request handshake (bit i = requester i)
//   req_op/req_a/req_b       packed request payloads, requester i at slice i
//   rsp_valid/rsp_ready      per-requester response handshake
//   rsp_y/rsp_flags/rsp_err  captured result, {carry,neg,zero,ovf}, bad-opcode flag
//   alu_control/alu_a/alu_b  operation presented to the shared ALU
//   alu_y, alu_carry/neg/zero/ovf  combinational ALU result and flags
//   busy                     high whenever an operation is in flight
module alu_arbiter #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned OP_W   = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [1:0]          req_valid,
   output logic [1:0]          req_ready,
   input  logic [2*OP_W-1:0]   req_op,
   input  logic [2*DATA_W-1:0] req_a,
   input  logic [2*DATA_W-1:0] req_b,
   output logic [1:0]          rsp_valid,
   input  logic [1:0]          rsp_ready,
   output logic [DATA_W-1:0]   rsp_y,
   output logic [3:0]          rsp_flags,
   output logic                rsp_err,
   output logic [OP_W-1:0]     alu_control,
   output logic [DATA_W-1:0]   alu_a,
   output logic [DATA_W-1:0]   alu_b,
   input  logic [DATA_W-1:0]   alu_y,
   input  logic                alu_carry,
   input  logic                alu_neg,
   input  logic                alu_zero,
   input  logic                alu_ovf,
   output logic                busy
);

   localparam int unsigned FLAG_W     = 4;
   localparam int unsigned BAD_OP_MIN = 13;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic                last_grant_q, last_grant_d;
   logic                winner_q, winner_d;
   logic [OP_W-1:0]     alu_control_q, alu_control_d;
   logic [DATA_W-1:0]   alu_a_q, alu_a_d;
   logic [DATA_W-1:0]   alu_b_q, alu_b_d;
   logic [DATA_W-1:0]   rsp_y_q, rsp_y_d;
   logic [FLAG_W-1:0]   rsp_flags_q, rsp_flags_d;
   logic                rsp_err_q, rsp_err_d;
   logic [1:0]          rsp_valid_q, rsp_valid_d;
   logic                busy_q, busy_d;

   logic                win_c;
   logic                accept_c;
   logic                bad_op_c;

   // Round-robin pick: a lone requester wins, a tie goes to the one not granted last
   always_comb begin
      win_c = req_valid[1];
      if (req_valid == 2'b11) begin
         win_c = ~last_grant_q;
      end
   end

   // Ready only to the valid winner, only in IDLE, and never while reset is sampled
   always_comb begin
      req_ready = 2'b00;
      if ((state_q == IDLE) && !rst) begin
         req_ready[win_c] = req_valid[win_c];
      end
   end

   assign accept_c = |(req_valid & req_ready);

   // The registered opcode doubles as the ALU control, so it is the one to classify
   assign bad_op_c = (alu_control_q >= OP_W'(BAD_OP_MIN));

   // Next-state and datapath updates
   always_comb begin
      state_d       = state_q;
      last_grant_d  = last_grant_q;
      winner_d      = winner_q;
      alu_control_d = alu_control_q;
      alu_a_d       = alu_a_q;
      alu_b_d       = alu_b_q;
      rsp_y_d       = rsp_y_q;
      rsp_flags_d   = rsp_flags_q;
      rsp_err_d     = rsp_err_q;
      rsp_valid_d   = rsp_valid_q;
      busy_d        = busy_q;

      case (state_q)
         IDLE: begin
            if (accept_c) begin
               state_d       = EXEC;
               last_grant_d  = win_c;
               winner_d      = win_c;
               alu_control_d = win_c ? req_op[2*OP_W-1:OP_W]   : req_op[OP_W-1:0];
               alu_a_d       = win_c ? req_a[2*DATA_W-1:DATA_W] : req_a[DATA_W-1:0];
               alu_b_d       = win_c ? req_b[2*DATA_W-1:DATA_W] : req_b[DATA_W-1:0];
               busy_d        = 1'b1;
            end
         end
         EXEC: begin
            state_d     = RESP;
            rsp_valid_d = winner_q ? 2'b10 : 2'b01;
            if (bad_op_c) begin
               rsp_y_d     = '0;
               rsp_flags_d = '0;
               rsp_err_d   = 1'b1;
            end else begin
               rsp_y_d     = alu_y;
               rsp_flags_d = {alu_carry, alu_neg, alu_zero, alu_ovf};
               rsp_err_d   = 1'b0;
            end
         end
         RESP: begin
            // Only the winner's ready completes the response
            if (rsp_ready[winner_q]) begin
               state_d     = IDLE;
               rsp_valid_d = 2'b00;
               busy_d      = 1'b0;
            end
         end
         default: begin
            state_d     = IDLE;
            rsp_valid_d = 2'b00;
            busy_d      = 1'b0;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         last_grant_q  <= 1'b1;
         winner_q      <= 1'b0;
         alu_control_q <= '0;
         alu_a_q       <= '0;
         alu_b_q       <= '0;
         rsp_y_q       <= '0;
         rsp_flags_q   <= '0;
         rsp_err_q     <= 1'b0;
         rsp_valid_q   <= 2'b00;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         last_grant_q  <= last_grant_d;
         winner_q      <= winner_d;
         alu_control_q <= alu_control_d;
         alu_a_q       <= alu_a_d;
         alu_b_q       <= alu_b_d;
         rsp_y_q       <= rsp_y_d;
         rsp_flags_q   <= rsp_flags_d;
         rsp_err_q     <= rsp_err_d;
         rsp_valid_q   <= rsp_valid_d;
         busy_q        <= busy_d;
      end
   end

   assign alu_control = alu_control_q;
   assign alu_a       = alu_a_q;
   assign alu_b       = alu_b_q;
   assign rsp_y       = rsp_y_q;
   assign rsp_flags   = rsp_flags_q;
   assign rsp_err     = rsp_err_q;
   assign rsp_valid   = rsp_valid_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: self-checking bench for alu_arbiter. Provides a behavioural
// ALU on the alu_* port and checks responses, grants and timing against a
// transaction-level model (pending requests per requester + last grant).
module tb_alu_arbiter;

   localparam int unsigned DW = 32;
   localparam int unsigned OW = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic [1:0]      req_valid, req_ready, rsp_valid, rsp_ready;
   logic [2*OW-1:0] req_op;
   logic [2*DW-1:0] req_a, req_b;
   logic [DW-1:0]   rsp_y, alu_a, alu_b, alu_y;
   logic [3:0]      rsp_flags;
   logic            rsp_err;
   logic [OW-1:0]   alu_control;
   logic            alu_carry, alu_neg, alu_zero, alu_ovf, busy;

   int total = 0;
   int bad   = 0;

   // Model state: last granted requester and each requester's pending request
   logic        model_last;
   logic [1:0]  pend;
   logic [3:0]  p_op [2];
   logic [31:0] p_a  [2];
   logic [31:0] p_b  [2];

   alu_arbiter #(.DATA_W(DW), .OP_W(OW)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_a(req_a), .req_b(req_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_y(rsp_y), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
      .alu_control(alu_control), .alu_a(alu_a), .alu_b(alu_b),
      .alu_y(alu_y), .alu_carry(alu_carry), .alu_neg(alu_neg),
      .alu_zero(alu_zero), .alu_ovf(alu_ovf),
      .busy(busy)
   );

   always #5 clk = ~clk;

   // Behavioural ALU: returns {y, carry, neg, zero, ovf}; 13..15 give junk on purpose
   function automatic logic [35:0] alu_fn(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
      logic [32:0] wide;
      logic [31:0] y;
      logic        c, v;
      wide = '0; y = '0; c = 1'b0; v = 1'b0;
      case (op)
         4'd0:  y = a | b;
         4'd1:  y = a & b;
         4'd2:  y = a ^ b;
         4'd3:  y = ~(a | b);
         4'd4:  y = a << b[4:0];
         4'd5:  y = a >> b[4:0];
         4'd6:  begin
            wide = {1'b0, a} + {1'b0, b};
            y = wide[31:0]; c = wide[32];
            v = (a[31] == b[31]) && (y[31] != a[31]);
         end
         4'd7:  begin
            y = a - b; c = (a < b);
            v = (a[31] != b[31]) && (y[31] != a[31]);
         end
         4'd8:  y = {31'd0, ($signed(a) < $signed(b))};
         4'd9:  y = {31'd0, (a < b)};
         4'd10: y = a;
         4'd11: y = b;
         4'd12: y = ~a;
         default: return {a ^ b ^ 32'hA5A5_5A5A, 4'hF};
      endcase
      return {y, c, y[31], (y == 32'd0), v};
   endfunction

   // Expected captured response {y, flags, err}
   function automatic logic [36:0] exp_fn(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
      if (op >= 4'd13) return {32'd0, 4'd0, 1'b1};
      return {alu_fn(op, a, b), 1'b0};
   endfunction

   function automatic logic [1:0] onehot(input logic w);
      return w ? 2'b10 : 2'b01;
   endfunction

   assign {alu_y, alu_carry, alu_neg, alu_zero, alu_ovf} = alu_fn(alu_control, alu_a, alu_b);

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reqs();
      req_valid = pend;
      req_op    = {p_op[1], p_op[0]};
      req_a     = {p_a[1], p_a[0]};
      req_b     = {p_b[1], p_b[0]};
   endtask

   task automatic load(input int r, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b);
      pend[r] = 1'b1; p_op[r] = op; p_a[r] = a; p_b[r] = b;
   endtask

   function automatic logic [31:0] rand_operand();
      case ($urandom_range(0, 4))
         0: return 32'd0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   task automatic load_rand(input int r, input int max_op);
      load(r, 4'($urandom_range(0, max_op)), rand_operand(), rand_operand());
   endtask

   task automatic test_reset();
      rst = 1'b1; rsp_ready = 2'b11;
      load(0, 4'd6, 32'd1, 32'd1); load(1, 4'd7, 32'd2, 32'd1); apply_reqs();
      tick(); #1;
      total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL reset_req_ready: got %b want 00", req_ready); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      total++; if (rsp_valid !== 2'b00) begin bad++; $display("FAIL reset_rsp_valid: got %b want 00", rsp_valid); end
      total++; if ({rsp_y, rsp_flags, rsp_err} !== 37'd0) begin bad++; $display("FAIL reset_rsp: got %h want 0", {rsp_y, rsp_flags, rsp_err}); end
      total++; if ({alu_control, alu_a, alu_b} !== 68'd0) begin bad++; $display("FAIL reset_alu: got %h want 0", {alu_control, alu_a, alu_b}); end
      tick();
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_priority_busy: got %b want 0", busy); end
      rst = 1'b0; rsp_ready = 2'b00; pend = 2'b00; apply_reqs();
      model_last = 1'b1;
   endtask

   task automatic test_single();
      load(0, 4'd6, 32'd5, 32'd7); apply_reqs(); #1;
      total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL single_ready: got %b want 01", req_ready); end
      tick();
      pend = 2'b00; apply_reqs(); #1;
      total++; if (busy !== 1'b1 || rsp_valid !== 2'b00) begin bad++; $display("FAIL single_exec: got busy=%b rsp_valid=%b want 1/00", busy, rsp_valid); end
      total++; if ({alu_control, alu_a, alu_b} !== {4'd6, 32'd5, 32'd7}) begin bad++; $display("FAIL single_alu: got %h want %h", {alu_control, alu_a, alu_b}, {4'd6, 32'd5, 32'd7}); end
      tick();
      total++; if (rsp_valid !== 2'b01) begin bad++; $display("FAIL single_rsp_valid: got %b want 01", rsp_valid); end
      total++; if ({rsp_y, rsp_flags, rsp_err} !== {32'd12, 4'b0000, 1'b0}) begin bad++; $display("FAIL single_rsp: got %h want %h", {rsp_y, rsp_flags, rsp_err}, {32'd12, 4'b0000, 1'b0}); end
      rsp_ready = 2'b01;
      tick();
      rsp_ready = 2'b00;
      total++; if (rsp_valid !== 2'b00 || busy !== 1'b0) begin bad++; $display("FAIL single_done: got rsp_valid=%b busy=%b want 00/0", rsp_valid, busy); end
      total++; if (alu_control !== 4'd6) begin bad++; $display("FAIL single_alu_hold: got %0d want 6", alu_control); end
      model_last = 1'b0;
   endtask

   task automatic test_tie();
      logic [1:0]  want_valid [2];
      logic [36:0] want_rsp   [2];
      want_valid[0] = 2'b01; want_rsp[0] = {32'd0, 4'b0010, 1'b0};
      want_valid[1] = 2'b10; want_rsp[1] = {32'd3, 4'b0000, 1'b0};
      load(0, 4'd7, 32'd3, 32'd3); load(1, 4'd0, 32'd1, 32'd2); apply_reqs();
      for (int k = 0; k < 2; k++) begin
         #1;
         total++; if (req_ready !== want_valid[k]) begin bad++; $display("FAIL tie_ready%0d: got %b want %b", k, req_ready, want_valid[k]); end
         tick();
         pend[k] = 1'b0; apply_reqs();
         tick();
         total++; if (rsp_valid !== want_valid[k]) begin bad++; $display("FAIL tie_rsp_valid%0d: got %b want %b", k, rsp_valid, want_valid[k]); end
         total++; if ({rsp_y, rsp_flags, rsp_err} !== want_rsp[k]) begin bad++; $display("FAIL tie_rsp%0d: got %h want %h", k, {rsp_y, rsp_flags, rsp_err}, want_rsp[k]); end
         rsp_ready = want_valid[k];
         tick();
         rsp_ready = 2'b00;
      end
      model_last = 1'b1;
   endtask

   task automatic test_fairness();
      logic [36:0] e;
      logic [1:0]  grant;
      load_rand(0, 12); load_rand(1, 12); apply_reqs();
      for (int k = 0; k < 6; k++) begin
         grant = onehot(k[0]);
         #1;
         total++; if (req_ready !== grant) begin bad++; $display("FAIL fair_grant%0d: got %b want %b", k, req_ready, grant); end
         tick();
         e = exp_fn(p_op[k[0]], p_a[k[0]], p_b[k[0]]);
         load_rand(k[0] ? 1 : 0, 12); apply_reqs();
         tick();
         total++; if (rsp_valid !== grant || {rsp_y, rsp_flags, rsp_err} !== e) begin bad++; $display("FAIL fair_rsp%0d: got %b/%h want %b/%h", k, rsp_valid, {rsp_y, rsp_flags, rsp_err}, grant, e); end
         rsp_ready = grant;
         tick();
         rsp_ready = 2'b00;
      end
      pend = 2'b00; apply_reqs();
      model_last = 1'b1;
   endtask

   task automatic test_backpressure();
      logic [36:0] e;
      load(0, 4'd6, rand_operand(), rand_operand()); apply_reqs(); #1;
      total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL bp_ready: got %b want 01", req_ready); end
      tick();
      e = exp_fn(p_op[0], p_a[0], p_b[0]);
      pend[0] = 1'b0; load(1, 4'd10, 32'h1234_5678, 32'd0); apply_reqs();
      tick();
      rsp_ready = 2'b10;
      for (int s = 0; s < 5; s++) begin
         #1;
         total++; if (rsp_valid !== 2'b01 || {rsp_y, rsp_flags, rsp_err} !== e) begin bad++; $display("FAIL bp_hold%0d: got %b/%h want 01/%h", s, rsp_valid, {rsp_y, rsp_flags, rsp_err}, e); end
         total++; if (busy !== 1'b1 || req_ready !== 2'b00) begin bad++; $display("FAIL bp_busy%0d: got busy=%b req_ready=%b want 1/00", s, busy, req_ready); end
         tick();
      end
      rsp_ready = 2'b01;
      tick();
      rsp_ready = 2'b00; #1;
      // The request raised during the busy period is served next
      total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL bp_pending_ready: got %b want 10", req_ready); end
      tick();
      pend = 2'b00; apply_reqs();
      tick();
      total++; if (rsp_valid !== 2'b10 || rsp_y !== 32'h1234_5678) begin bad++; $display("FAIL bp_pending_rsp: got %b/%h want 10/12345678", rsp_valid, rsp_y); end
      rsp_ready = 2'b10;
      tick();
      rsp_ready = 2'b00;
      model_last = 1'b1;
   endtask

   task automatic test_unsupported();
      load(1, 4'd14, 32'hFFFF_0000, 32'h0000_1111); apply_reqs(); #1;
      total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL unsup_ready: got %b want 10", req_ready); end
      tick();
      pend = 2'b00; apply_reqs(); #1;
      total++; if (alu_control !== 4'd14) begin bad++; $display("FAIL unsup_alu: got %0d want 14", alu_control); end
      tick();
      total++; if (rsp_valid !== 2'b10 || {rsp_y, rsp_flags, rsp_err} !== {32'd0, 4'd0, 1'b1}) begin bad++; $display("FAIL unsup_rsp: got %b/%h want 10/%h", rsp_valid, {rsp_y, rsp_flags, rsp_err}, {32'd0, 4'd0, 1'b1}); end
      rsp_ready = 2'b10;
      tick();
      rsp_ready = 2'b00;
      model_last = 1'b1;
   endtask

   task automatic test_drop();
      load(0, 4'd2, 32'hF0F0_0000, 32'h0F0F_0000); apply_reqs();
      tick();
      pend[0] = 1'b0; load(1, 4'd3, 32'd9, 32'd9); apply_reqs(); #1;
      total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL drop_ready_exec: got %b want 00", req_ready); end
      tick();
      pend[1] = 1'b0; apply_reqs(); rsp_ready = 2'b01;
      tick();
      rsp_ready = 2'b00;
      for (int s = 0; s < 3; s++) begin
         #1;
         total++; if (busy !== 1'b0 || alu_control !== 4'd2) begin bad++; $display("FAIL drop_no_effect%0d: got busy=%b op=%0d want 0/2", s, busy, alu_control); end
         tick();
      end
      model_last = 1'b0;
   endtask

   task automatic test_reset_abort();
      for (int stage = 1; stage <= 2; stage++) begin
         load(0, 4'd6, 32'd100, 32'd23); apply_reqs();
         tick();
         pend = 2'b00; apply_reqs();
         if (stage == 2) tick();
         rst = 1'b1; rsp_ready = 2'b11;
         tick();
         rst = 1'b0;
         total++; if (busy !== 1'b0 || rsp_valid !== 2'b00) begin bad++; $display("FAIL abort%0d_state: got busy=%b rsp_valid=%b want 0/00", stage, busy, rsp_valid); end
         total++; if ({rsp_y, rsp_err, alu_control} !== 37'd0) begin bad++; $display("FAIL abort%0d_regs: got %h want 0", stage, {rsp_y, rsp_err, alu_control}); end
         for (int s = 0; s < 3; s++) begin
            tick();
            total++; if (rsp_valid !== 2'b00) begin bad++; $display("FAIL abort%0d_no_rsp%0d: got %b want 00", stage, s, rsp_valid); end
         end
         rsp_ready = 2'b00;
      end
      model_last = 1'b1;
   endtask

   task automatic test_random_traffic();
      logic        w;
      logic [36:0] e;
      logic [3:0]  op_w;
      logic [31:0] a_w, b_w;
      int          stall;
      for (int n = 0; n < 40; n++) begin
         for (int r = 0; r < 2; r++) if (!pend[r] && $urandom_range(0, 1) == 1) load_rand(r, 15);
         if (pend == 2'b00) load_rand(int'($urandom_range(0, 1)), 15);
         apply_reqs(); #1;
         w = (pend == 2'b11) ? !model_last : pend[1];
         total++; if (req_ready !== onehot(w) || busy !== 1'b0) begin bad++; $display("FAIL rnd%0d_grant: got %b busy=%b want %b", n, req_ready, busy, onehot(w)); end
         tick();
         op_w = p_op[w]; a_w = p_a[w]; b_w = p_b[w];
         e = exp_fn(op_w, a_w, b_w);
         pend[w] = 1'b0;
         for (int r = 0; r < 2; r++) if (!pend[r] && $urandom_range(0, 3) == 0) load_rand(r, 15);
         apply_reqs(); #1;
         total++; if ({alu_control, alu_a, alu_b} !== {op_w, a_w, b_w} || req_ready !== 2'b00) begin bad++; $display("FAIL rnd%0d_exec: got %h rdy=%b want %h", n, {alu_control, alu_a, alu_b}, req_ready, {op_w, a_w, b_w}); end
         tick();
         stall = int'($urandom_range(0, 3));
         for (int s = 0; s <= stall; s++) begin
            rsp_ready = ($urandom_range(0, 1) == 1) ? onehot(!w) : 2'b00;
            if (s == stall) rsp_ready = rsp_ready | onehot(w);
            #1;
            total++; if (rsp_valid !== onehot(w) || {rsp_y, rsp_flags, rsp_err} !== e || req_ready !== 2'b00) begin bad++; $display("FAIL rnd%0d_rsp: got %b/%h want %b/%h", n, rsp_valid, {rsp_y, rsp_flags, rsp_err}, onehot(w), e); end
            tick();
         end
         rsp_ready = 2'b00;
         total++; if (rsp_valid !== 2'b00 || busy !== 1'b0) begin bad++; $display("FAIL rnd%0d_done: got %b busy=%b want 00/0", n, rsp_valid, busy); end
         model_last = w;
      end
      pend = 2'b00; apply_reqs();
   endtask

   initial begin
      rst = 1'b1; rsp_ready = 2'b00; pend = 2'b00;
      for (int r = 0; r < 2; r++) begin p_op[r] = '0; p_a[r] = '0; p_b[r] = '0; end
      apply_reqs();
      model_last = 1'b1;
      test_reset();
      test_single();
      test_reset();
      test_tie();
      test_fairness();
      test_backpressure();
      test_unsupported();
      test_drop();
      test_reset_abort();
      test_random_traffic();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
